// File: rtl/serial_mac_fir.sv
// Serial multiply-accumulate FIR filter.
// A single MAC unit walks the taps one per clock, so each result takes LENGTH
// MAC cycles plus one accept and one hand-off cycle. Coefficients live in a
// small addressable RAM. The delay line can be flushed. The final sum is
// arithmetically shifted and then clamped to the signed output range.
module serial_mac_fir #(
    parameter int LENGTH      = 20,
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int OUT_WIDTH   = 19,
    parameter int OUT_SHIFT   = 0,
    localparam int ADDR_WIDTH = $clog2(LENGTH),
    localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + $clog2(LENGTH)
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   coeffWrite,
    input  logic [ADDR_WIDTH-1:0]  coeffAddr,
    input  logic [COEFF_WIDTH-1:0] coeffIn,
    input  logic                   flush,
    input  logic                   dataInValid,
    output logic                   dataInReady,
    input  logic [DATA_WIDTH-1:0]  dataIn,
    output logic                   dataOutValid,
    input  logic                   dataOutReady,
    output logic [OUT_WIDTH-1:0]   dataOut,
    output logic                   saturated
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam int CMP_WIDTH  = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH;

    localparam logic signed [CMP_WIDTH-1:0] OUT_MAX =
        {{(CMP_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [CMP_WIDTH-1:0] OUT_MIN =
        {{(CMP_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MAC  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [DATA_WIDTH-1:0]  x_line [LENGTH];
    logic signed [COEFF_WIDTH-1:0] h_coef [LENGTH];
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [ADDR_WIDTH-1:0]         tap_count;

    logic signed [PROD_WIDTH-1:0]  product;
    logic signed [ACC_WIDTH-1:0]   mac_sum;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic signed [CMP_WIDTH-1:0]   s_wide;
    logic [OUT_WIDTH-1:0]          sat_value;
    logic                          sat_flag;
    logic                          last_tap;
    logic                          addr_in_range;

    assign dataInReady   = (state == IDLE);
    assign last_tap      = (tap_count == ADDR_WIDTH'(LENGTH - 1));
    assign addr_in_range = (32'(coeffAddr) < LENGTH);

    assign product = x_line[tap_count] * h_coef[tap_count];
    assign mac_sum = acc + ACC_WIDTH'(product);
    assign shifted = mac_sum >>> OUT_SHIFT;
    assign s_wide  = CMP_WIDTH'(shifted);

    // Clamp the shifted final sum into the signed output range.
    always_comb begin
        sat_value = s_wide[OUT_WIDTH-1:0];
        sat_flag  = 1'b0;
        if (s_wide > OUT_MAX) begin
            sat_value = OUT_MAX[OUT_WIDTH-1:0];
            sat_flag  = 1'b1;
        end else if (s_wide < OUT_MIN) begin
            sat_value = OUT_MIN[OUT_WIDTH-1:0];
            sat_flag  = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept, run all taps, then wait for the consumer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (dataInValid) next_state = MAC;
            MAC:  if (last_tap) next_state = HOLD;
            HOLD: if (dataOutReady) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: coefficient RAM, delay line, accumulator and output register.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            for (int k = 0; k < LENGTH; k++) begin
                h_coef[k] <= '0;
                x_line[k] <= '0;
            end
            acc          <= '0;
            tap_count    <= '0;
            dataOut      <= '0;
            dataOutValid <= 1'b0;
            saturated    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (coeffWrite && addr_in_range) begin
                        h_coef[coeffAddr] <= coeffIn;
                    end
                    if (dataInValid) begin
                        for (int k = LENGTH - 1; k >= 1; k--) begin
                            x_line[k] <= flush ? '0 : x_line[k-1];
                        end
                        x_line[0] <= dataIn;
                        acc       <= '0;
                        tap_count <= '0;
                    end else if (flush) begin
                        for (int k = 0; k < LENGTH; k++) begin
                            x_line[k] <= '0;
                        end
                    end
                end
                MAC: begin
                    acc       <= mac_sum;
                    tap_count <= tap_count + ADDR_WIDTH'(1);
                    if (last_tap) begin
                        dataOut      <= sat_value;
                        saturated    <= sat_flag;
                        dataOutValid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (dataOutReady) begin
                        dataOutValid <= 1'b0;
                    end
                end
                default: begin
                    dataOutValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mac_fir.sv
// Self-checking bench for serial_mac_fir.
// The reference model keeps plain integer arrays for coefficients and the
// sample history. It computes each expected result as a dot product followed
// by shifting and clamping.
module tb_serial_mac_fir;

    localparam int LENGTH      = 20;
    localparam int DATA_WIDTH  = 8;
    localparam int COEFF_WIDTH = 8;
    localparam int OUT_WIDTH   = 19;
    localparam int OUT_SHIFT   = 0;
    localparam int ADDR_WIDTH  = $clog2(LENGTH);

    logic                          clock = 1'b0;
    logic                          resetN;
    logic                          coeffWrite;
    logic [ADDR_WIDTH-1:0]         coeffAddr;
    logic [COEFF_WIDTH-1:0]        coeffIn;
    logic                          flush;
    logic                          dataInValid;
    logic                          dataInReady;
    logic [DATA_WIDTH-1:0]         dataIn;
    logic                          dataOutValid;
    logic                          dataOutReady;
    logic signed [OUT_WIDTH-1:0]   dataOut;
    logic                          saturated;

    int compared   = 0;
    int mismatched = 0;

    int h_model [LENGTH];
    int x_model [LENGTH];

    serial_mac_fir #(
        .LENGTH(LENGTH), .DATA_WIDTH(DATA_WIDTH), .COEFF_WIDTH(COEFF_WIDTH),
        .OUT_WIDTH(OUT_WIDTH), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clock(clock), .resetN(resetN), .coeffWrite(coeffWrite),
        .coeffAddr(coeffAddr), .coeffIn(coeffIn), .flush(flush),
        .dataInValid(dataInValid), .dataInReady(dataInReady), .dataIn(dataIn),
        .dataOutValid(dataOutValid), .dataOutReady(dataOutReady),
        .dataOut(dataOut), .saturated(saturated)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic void modelReset();
        for (int k = 0; k < LENGTH; k++) begin
            h_model[k] = 0;
            x_model[k] = 0;
        end
    endfunction

    function automatic longint modelExpected(output bit sat);
        longint acc = 0;
        longint s;
        longint max_v = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
        longint min_v = -max_v - 1;
        for (int k = 0; k < LENGTH; k++) acc += longint'(h_model[k]) * x_model[k];
        s = acc >>> OUT_SHIFT;
        sat = 1'b1;
        if (s > max_v) return max_v;
        if (s < min_v) return min_v;
        sat = 1'b0;
        return s;
    endfunction

    task automatic resetDut();
        resetN = 1'b0; coeffWrite = 1'b0; flush = 1'b0;
        dataInValid = 1'b0; dataOutReady = 1'b1;
        coeffAddr = '0; coeffIn = '0; dataIn = '0;
        step();
        resetN = 1'b1;
        modelReset();
    endtask

    task automatic writeCoeff(input int addr, input int val);
        coeffWrite = 1'b1;
        coeffAddr  = ADDR_WIDTH'(addr);
        coeffIn    = COEFF_WIDTH'(val);
        step();
        coeffWrite = 1'b0;
        if (addr < LENGTH) h_model[addr] = val;
    endtask

    task automatic idleFlush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < LENGTH; k++) x_model[k] = 0;
    endtask

    // Accept one sample, run it to completion, optionally backpressure, release.
    task automatic applyStimulus(input int sample, input bit do_flush, input bit do_write,
                                 input int waddr, input int wval, input int hold_cycles,
                                 input bit mid_write, output longint got);
        int  guard = 0;
        int  cycles;
        bit  exp_sat;
        longint exp_val;
        logic signed [OUT_WIDTH-1:0] held;
        got = -999999;
        while (!dataInReady && guard < 100) begin
            step();
            guard++;
        end
        if (!dataInReady) begin
            checkOutput("in_ready_timeout", 0, 1);
            return;
        end
        dataOutReady = (hold_cycles == 0);
        dataInValid  = 1'b1;
        dataIn       = DATA_WIDTH'(sample);
        flush        = do_flush;
        coeffWrite   = do_write;
        coeffAddr    = ADDR_WIDTH'(waddr);
        coeffIn      = COEFF_WIDTH'(wval);
        step();
        coeffWrite = 1'b0;
        flush      = 1'b0;
        if (do_write && waddr < LENGTH) h_model[waddr] = wval;
        if (do_flush) for (int k = 0; k < LENGTH; k++) x_model[k] = 0;
        for (int k = LENGTH - 1; k >= 1; k--) x_model[k] = x_model[k-1];
        x_model[0] = sample;
        exp_val = modelExpected(exp_sat);

        cycles = 1;
        while (!dataOutValid && cycles < LENGTH + 10) begin
            dataInValid = 1'b1;
            dataIn      = DATA_WIDTH'(55);
            coeffWrite  = mid_write && (cycles == 3);
            flush       = mid_write && (cycles == 3);
            coeffAddr   = '0;
            coeffIn     = COEFF_WIDTH'(99);
            if (cycles == 2) checkOutput("ready_in_mac", dataInReady, 0);
            step();
            cycles++;
        end
        dataInValid = 1'b0;
        coeffWrite  = 1'b0;
        flush       = 1'b0;
        checkOutput("latency", cycles, LENGTH + 1);
        if (!dataOutValid) return;
        checkOutput("data", dataOut, exp_val);
        checkOutput("sat", saturated, exp_sat);
        held = dataOut;
        got  = dataOut;

        for (int i = 0; i < hold_cycles; i++) begin
            dataInValid = 1'b1;
            dataIn      = DATA_WIDTH'(77);
            step();
            checkOutput("hold_data", dataOut, held);
            checkOutput("hold_valid", dataOutValid, 1);
            checkOutput("hold_in_ready", dataInReady, 0);
        end
        dataInValid  = 1'b0;
        dataOutReady = 1'b1;
        step();
        checkOutput("release_valid", dataOutValid, 0);
        checkOutput("release_in_ready", dataInReady, 1);
    endtask

    initial begin
        longint got;
        int     seen;
        resetDut();

        // Reset state.
        checkOutput("reset_dataOut", dataOut, 0);
        checkOutput("reset_valid", dataOutValid, 0);
        checkOutput("reset_sat", saturated, 0);
        checkOutput("reset_in_ready", dataInReady, 1);

        // Impulse response through ramp coefficients, back-to-back.
        for (int k = 0; k < LENGTH; k++) writeCoeff(k, k + 1);
        for (int i = 0; i <= LENGTH; i++) begin
            applyStimulus((i == 0) ? 1 : 0, 0, 0, 0, 0, 0, 0, got);
            checkOutput("impulse", got, (i < LENGTH) ? i + 1 : 0);
        end

        // Backpressure with the input side pushing.
        applyStimulus(1, 0, 0, 0, 0, 10, 0, got);
        checkOutput("backpressure_out", got, 1);

        // Ignored writes: out-of-range address and writes/flush during MAC.
        writeCoeff(25, 55);
        for (int i = 0; i < LENGTH; i++) begin
            applyStimulus((i == 0) ? 1 : 0, i == 0, 0, 0, 0, 0, i == 0, got);
            checkOutput("ignored_write", got, i + 1);
        end
        applyStimulus(1, 1, 1, 0, 77, 0, 0, got);
        checkOutput("same_edge_write", got, 77);
        writeCoeff(0, 1);

        // Flush in IDLE, then flush on the accept edge.
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, got);
        idleFlush();
        for (int i = 0; i < 3; i++) begin
            applyStimulus((i == 0) ? 1 : 0, 0, 0, 0, 0, 0, 0, got);
            checkOutput("idle_flush", got, i + 1);
        end
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, got);
        for (int i = 0; i < 3; i++) begin
            applyStimulus((i == 0) ? 1 : 0, i == 0, 0, 0, 0, 0, 0, got);
            checkOutput("accept_flush", got, i + 1);
        end

        // Positive saturation.
        for (int k = 0; k < LENGTH; k++) writeCoeff(k, 127);
        for (int i = 0; i < LENGTH; i++) begin
            applyStimulus(127, i == 0, 0, 0, 0, 0, 0, got);
            if (i == 0) begin
                checkOutput("sat_first", got, 16129);
                checkOutput("sat_first_flag", saturated, 0);
            end
            if (i >= LENGTH - 2) begin
                checkOutput("sat_pos", got, 262143);
                checkOutput("sat_pos_flag", saturated, 1);
            end
        end

        // Negative saturation.
        for (int k = 0; k < LENGTH; k++) writeCoeff(k, -128);
        for (int i = 0; i < LENGTH; i++) applyStimulus(127, i == 0, 0, 0, 0, 0, 0, got);
        checkOutput("sat_neg", got, -262144);
        checkOutput("sat_neg_flag", saturated, 1);

        // Reset in the middle of MAC aborts the sample and clears coefficients.
        for (int k = 0; k < LENGTH; k++) writeCoeff(k, k + 1);
        idleFlush();
        dataInValid = 1'b1;
        dataIn      = DATA_WIDTH'(1);
        step();
        dataInValid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        modelReset();
        checkOutput("abort_valid", dataOutValid, 0);
        checkOutput("abort_dataOut", dataOut, 0);
        checkOutput("abort_in_ready", dataInReady, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dataOutValid) seen++;
        end
        checkOutput("abort_no_output", seen, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus((i == 0) ? 1 : 0, 0, 0, 0, 0, 0, 0, got);
            checkOutput("cleared_coeffs", got, 0);
        end

        // Randomized traffic against the model.
        resetDut();
        for (int k = 0; k < LENGTH; k++) writeCoeff(k, int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 8; i++) writeCoeff(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, 255)) - 128,
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 255)) - 128,
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0,
                          ($urandom_range(0, 4) == 0),
                          got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
